// File: rtl/rv32_alu.sv
// rv32_alu -- RV32IM execute-stage ALU.
//   Single-cycle integer and multiply operations are purely combinational.
//   DIV/DIVU/REM/REMU run on a 32-step restoring divider that stalls the
//   pipeline through divReady.
// Ports:
//   CLK      in   1  clock, rising edge
//   RESET    in   1  asynchronous active-high reset
//   aluc     in   5  operation select
//   A, B     in  32  operands (rs1, rs2/immediate)
//   Result   out 32  operation result
//   zero     out  1  Result == 0
//   divReady out  1  low while a divide is pending or in progress
module rv32_alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  aluc,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        zero,
  output logic        divReady
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] dvd_q, dvd_d;       // dividend magnitude, shifts into quotient
  logic [31:0] rem_q, rem_d;       // partial remainder
  logic [31:0] dsr_q, dsr_d;       // divisor magnitude
  logic        is_rem_q, is_rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] div_res_q, div_res_d;

  logic        is_div_s;
  logic        div_signed_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] rem_shift_s, trial_s;
  logic [31:0] q_step_s, r_step_s;
  logic [63:0] p_ss_s, p_su_s, p_uu_s;
  logic [31:0] alu_s;

  // aluc 20..23 share the 3'b101 prefix; aluc[0] = unsigned, aluc[1] = remainder
  assign is_div_s     = (aluc[4:2] == 3'b101);
  assign div_signed_s = ~aluc[0];
  assign a_mag_s      = (div_signed_s && A[31]) ? (~A + 32'd1) : A;
  assign b_mag_s      = (div_signed_s && B[31]) ? (~B + 32'd1) : B;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow
  assign rem_shift_s = {rem_q, dvd_q[31]};
  assign trial_s     = rem_shift_s - {1'b0, dsr_q};
  assign q_step_s    = {dvd_q[30:0], ~trial_s[32]};
  assign r_step_s    = trial_s[32] ? rem_shift_s[31:0] : trial_s[31:0];

  // Sign/zero-extended operands so the low 64 bits of each product are exact
  assign p_ss_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign p_su_s = {{32{A[31]}}, A} * {32'd0, B};
  assign p_uu_s = {32'd0, A} * {32'd0, B};

  // Single-cycle operation results
  always_comb begin
    alu_s = 32'd0;
    case (aluc)
      5'd0:    alu_s = A + B;
      5'd1:    alu_s = A - B;
      5'd2:    alu_s = A & B;
      5'd3:    alu_s = A | B;
      5'd4:    alu_s = A ^ B;
      5'd5:    alu_s = A << B[4:0];
      5'd6:    alu_s = A >> B[4:0];
      5'd7:    alu_s = $signed(A) >>> B[4:0];
      5'd8:    alu_s = {31'd0, ($signed(A) < $signed(B))};
      5'd9:    alu_s = {31'd0, (A < B)};
      5'd10:   alu_s = B;
      5'd16:   alu_s = p_uu_s[31:0];
      5'd17:   alu_s = p_ss_s[63:32];
      5'd18:   alu_s = p_su_s[63:32];
      5'd19:   alu_s = p_uu_s[63:32];
      default: alu_s = 32'd0;
    endcase
  end

  // Divider next-state logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    is_rem_d  = is_rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div_res_d = div_res_q;
    case (state_q)
      ST_IDLE: begin
        if (is_div_s) begin
          is_rem_d = aluc[1];
          if (B == 32'd0) begin
            div_res_d = aluc[1] ? A : 32'hFFFF_FFFF;
            state_d   = ST_DONE;
          end else if (div_signed_s && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
            div_res_d = aluc[1] ? 32'd0 : 32'h8000_0000;
            state_d   = ST_DONE;
          end else begin
            dvd_d   = a_mag_s;
            dsr_d   = b_mag_s;
            rem_d   = 32'd0;
            count_d = 5'd0;
            negq_d  = div_signed_s & (A[31] ^ B[31]);
            negr_d  = div_signed_s & A[31];
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        dvd_d   = q_step_s;
        rem_d   = r_step_s;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          // Quotient truncates toward zero; remainder follows the dividend sign
          if (is_rem_q) begin
            div_res_d = negr_q ? (~r_step_s + 32'd1) : r_step_s;
          end else begin
            div_res_d = negq_q ? (~q_step_s + 32'd1) : q_step_s;
          end
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider state registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= 5'd0;
      dvd_q     <= 32'd0;
      rem_q     <= 32'd0;
      dsr_q     <= 32'd0;
      is_rem_q  <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      div_res_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      is_rem_q  <= is_rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      div_res_q <= div_res_d;
    end
  end

  // Result mux and stall handshake
  always_comb begin
    Result   = 32'd0;
    divReady = 1'b1;
    case (state_q)
      ST_IDLE: begin
        divReady = ~is_div_s;
        if (is_div_s) begin
          Result = div_res_q;
        end else begin
          Result = alu_s;
        end
      end
      ST_BUSY: begin
        divReady = 1'b0;
        Result   = 32'd0;
      end
      ST_DONE: begin
        divReady = 1'b1;
        Result   = div_res_q;
      end
      default: begin
        divReady = 1'b1;
        Result   = 32'd0;
      end
    endcase
  end

  assign zero = (Result == 32'd0);

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu -- directed-vector self-checking bench for rv32_alu.
module tb_rv32_alu;

  logic        CLK;
  logic        RESET;
  logic [4:0]  aluc;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        zero;
  logic        divReady;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_PASSB = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // expected edges to divReady; 0 = not checked
  } vec_t;

  vec_t alu_vecs[$];
  vec_t div_vecs[$];

  rv32_alu dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .aluc     (aluc),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .zero     (zero),
    .divReady (divReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    aluc = OP_ADD;
    A    = 32'd0;
    B    = 32'd0;
    tick();
  endtask

  task automatic run_div(input vec_t v);
    int    edges;
    string tag;
    tag  = $sformatf("div op%0d %h/%h", v.op, v.a, v.b);
    aluc = v.op;
    A    = v.a;
    B    = v.b;
    #1;
    // Presented while DONE: leave DONE first, the op starts from IDLE
    if (divReady) begin
      tick();
    end
    if (v.lat != 0) begin
      check_eq({tag, " ready_low"}, {31'd0, divReady}, 32'd0);
    end
    edges = 0;
    while (!divReady && edges < 60) begin
      tick();
      edges++;
    end
    check_eq({tag, " ready"}, {31'd0, divReady}, 32'd1);
    check_eq({tag, " result"}, Result, v.exp);
    check_eq({tag, " zero"}, {31'd0, zero}, {31'd0, (v.exp == 32'd0)});
    if (v.lat != 0) begin
      check_eq({tag, " latency"}, 32'(edges), 32'(v.lat));
    end
  endtask

  initial begin
    RESET = 1'b1;
    aluc  = OP_ADD;
    A     = 32'd0;
    B     = 32'd0;

    alu_vecs.push_back('{OP_ADD,    32'd7,          32'd8,          32'd15,         0});
    alu_vecs.push_back('{OP_SUB,    32'd5,          32'd5,          32'd0,          0});
    alu_vecs.push_back('{OP_SUB,    32'd0,          32'd1,          32'hFFFF_FFFF,  0});
    alu_vecs.push_back('{OP_AND,    32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  0});
    alu_vecs.push_back('{OP_OR,     32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  0});
    alu_vecs.push_back('{OP_XOR,    32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  0});
    alu_vecs.push_back('{OP_SLL,    32'd1,          32'd31,         32'h8000_0000,  0});
    alu_vecs.push_back('{OP_SRL,    32'h8000_0000,  32'd4,          32'h0800_0000,  0});
    alu_vecs.push_back('{OP_SRA,    32'h8000_0000,  32'd4,          32'hF800_0000,  0});
    alu_vecs.push_back('{OP_SRA,    32'h8000_0000,  32'h24,         32'hF800_0000,  0});
    alu_vecs.push_back('{OP_SLT,    32'hFFFF_FFFF,  32'd1,          32'd1,          0});
    alu_vecs.push_back('{OP_SLTU,   32'd1,          32'hFFFF_FFFF,  32'd1,          0});
    alu_vecs.push_back('{OP_SLTU,   32'hFFFF_FFFF,  32'd1,          32'd0,          0});
    alu_vecs.push_back('{OP_PASSB,  32'hDEAD_BEEF,  32'h1234_5000,  32'h1234_5000,  0});
    alu_vecs.push_back('{OP_MUL,    32'd7,          32'd6,          32'd42,         0});
    alu_vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          0});
    alu_vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  0});
    alu_vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0});
    alu_vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0});
    alu_vecs.push_back('{5'd11,     32'd3,          32'd4,          32'd0,          0});

    div_vecs.push_back('{OP_DIV,  32'd100,        32'd3,          32'd33,         33});
    div_vecs.push_back('{OP_DIVU, 32'd100,        32'd3,          32'd33,         33});
    div_vecs.push_back('{OP_REM,  32'd100,        32'd3,          32'd1,          33});
    div_vecs.push_back('{OP_REMU, 32'd100,        32'd3,          32'd1,          33});
    div_vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    div_vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    div_vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    div_vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    div_vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    div_vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    div_vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    div_vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    div_vecs.push_back('{OP_DIV,  32'd123,        32'd0,          32'hFFFF_FFFF,  1});
    div_vecs.push_back('{OP_REM,  32'd123,        32'd0,          32'h0000_007B,  1});
    div_vecs.push_back('{OP_DIVU, 32'd123,        32'd0,          32'hFFFF_FFFF,  1});
    div_vecs.push_back('{OP_REMU, 32'd123,        32'd0,          32'h0000_007B,  1});
    div_vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33});

    // Reset state
    #3;
    check_eq("rst ready", {31'd0, divReady}, 32'd1);
    check_eq("rst result", Result, 32'd0);
    check_eq("rst zero", {31'd0, zero}, 32'd1);
    aluc = OP_DIV;
    #1;
    check_eq("rst divres", Result, 32'd0);
    aluc = OP_ADD;
    tick();
    RESET = 1'b0;
    tick();

    // Single-cycle ops
    foreach (alu_vecs[i]) begin
      aluc = alu_vecs[i].op;
      A    = alu_vecs[i].a;
      B    = alu_vecs[i].b;
      #1;
      check_eq($sformatf("alu op%0d %h,%h result", aluc, A, B), Result, alu_vecs[i].exp);
      check_eq($sformatf("alu op%0d zero", aluc), {31'd0, zero}, {31'd0, (alu_vecs[i].exp == 32'd0)});
      check_eq($sformatf("alu op%0d ready", aluc), {31'd0, divReady}, 32'd1);
      tick();
    end

    // Divides from IDLE
    foreach (div_vecs[i]) begin
      run_div(div_vecs[i]);
      go_idle();
    end

    // Back-to-back: new divide presented in the cycle divReady rises
    run_div('{OP_DIV,  32'd100,       32'd3, 32'd33,        0});
    run_div('{OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0});
    run_div('{OP_DIVU, 32'd1000,      32'd7, 32'd142,       0});
    go_idle();

    // Inputs changed mid-BUSY are ignored, then RESET aborts the divide
    aluc = OP_DIVU;
    A    = 32'd100;
    B    = 32'd3;
    repeat (6) tick();
    aluc = OP_ADD;
    A    = 32'd2;
    B    = 32'd3;
    #1;
    check_eq("busy ready", {31'd0, divReady}, 32'd0);
    check_eq("busy result", Result, 32'd0);
    #1;
    RESET = 1'b1;
    #1;
    check_eq("abort ready", {31'd0, divReady}, 32'd1);
    check_eq("abort result", Result, 32'd5);
    aluc = OP_DIVU;
    #1;
    check_eq("abort divres", Result, 32'd0);
    aluc  = OP_ADD;
    #1;
    RESET = 1'b0;
    tick();
    run_div('{OP_DIVU, 32'd100, 32'd3, 32'd33, 33});
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
